// File: rtl/risk_pkg.sv
// risk_pkg: shared sizes, command encodings and tile type for the risk matrix unit.
package risk_pkg;

  localparam int unsigned SZ        = 4;
  localparam int unsigned BITS      = 18;
  localparam int unsigned NREG      = 32;
  localparam int unsigned NELEM     = SZ * SZ;
  localparam int unsigned AW        = 15;
  localparam int unsigned SW        = 14;
  localparam int unsigned RW        = 5;
  localparam int unsigned IW        = 4;
  localparam int unsigned MEM_WORDS = 1 << AW;

  typedef enum logic [2:0] {
    F_NOP    = 3'b000,
    F_LOAD   = 3'b001,
    F_STORE  = 3'b010,
    F_MULACC = 3'b011,
    F_ZERO   = 3'b100,
    F_RELU   = 3'b101
  } risk_func_e;

  // Element (x,y) sits at flat index 4*y+x, i.e. bits 18*(4*y+x) +: 18.
  typedef logic [NELEM-1:0][BITS-1:0] tile_t;

  function automatic logic [IW-1:0] elem_idx(input int unsigned x, input int unsigned y);
    return IW'(SZ * y + x);
  endfunction

endpackage

// File: rtl/risk_banked_mem.sv
// risk_banked_mem: 32K x 18 data memory, 16 write lanes and 16 registered read lanes.
// Lanes are applied in ascending order so the highest lane wins on a duplicate address.
module risk_banked_mem
  import risk_pkg::*;
(
  input  logic                      clk,
  input  logic [NELEM-1:0]          we,
  input  logic [NELEM-1:0][AW-1:0]  addr,
  input  tile_t                     wdata,
  output tile_t                     rdata
);

  logic [BITS-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NELEM; i++) begin
      if (we[i]) mem[addr[i]] <= wdata[i];
      rdata[i] <= mem[addr[i]];
    end
  end

endmodule

// File: rtl/risk_unit.sv
// risk_unit: 32-entry 4x4 tile register file with strided load/store, MAC and zero.
// Define RISK_RELU_EN to enable the in-place ReLU command (func 101).
module risk_unit
  import risk_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             risk_func,
  input  logic [RW-1:0]          risk_reg,
  input  logic [AW-1:0]          risk_addr,
  input  logic [SW-1:0]          risk_stride_x,
  input  logic [SW-1:0]          risk_stride_y,
  output logic [NELEM*BITS-1:0]  reg_view
);

  tile_t                    regs [NREG];
  logic [RW-1:0]            r1;
  logic [RW-1:0]            r2;
  logic [NELEM-1:0]         mem_we;
  logic [NELEM-1:0][AW-1:0] mem_addr;
  tile_t                    mem_rdata;
  logic                     ld_valid;
  logic [RW-1:0]            ld_reg;
  logic                     cmp_en_c;
  tile_t                    cmp_val_c;
  logic [BITS-1:0]          acc;

  assign r1 = risk_reg + RW'(1);
  assign r2 = risk_reg + RW'(2);

  // Strided effective address per element, wrapping at 2^15
  always_comb begin
    mem_addr = '0;
    for (int unsigned y = 0; y < SZ; y++) begin
      for (int unsigned x = 0; x < SZ; x++) begin
        mem_addr[elem_idx(x, y)] = risk_addr + AW'(x) * AW'(risk_stride_x)
                                             + AW'(y) * AW'(risk_stride_y);
      end
    end
  end

  // Stores are suppressed while reset is held
  assign mem_we = {NELEM{rst_n && (risk_func == F_STORE)}};

  risk_banked_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (regs[risk_reg]),
    .rdata (mem_rdata)
  );

  // Single-cycle compute commands: C = R[r] + R[r+1] x R[r+2], zero, optional ReLU
  always_comb begin
    cmp_en_c  = 1'b0;
    cmp_val_c = '0;
    acc       = '0;
    case (risk_func)
      F_MULACC: begin
        cmp_en_c = 1'b1;
        for (int unsigned y = 0; y < SZ; y++) begin
          for (int unsigned x = 0; x < SZ; x++) begin
            acc = regs[risk_reg][elem_idx(x, y)];
            for (int unsigned k = 0; k < SZ; k++) begin
              acc = acc + BITS'(regs[r1][elem_idx(k, y)] * regs[r2][elem_idx(x, k)]);
            end
            cmp_val_c[elem_idx(x, y)] = acc;
          end
        end
      end
      F_ZERO: begin
        cmp_en_c = 1'b1;
      end
`ifdef RISK_RELU_EN
      F_RELU: begin
        cmp_en_c = 1'b1;
        for (int i = 0; i < NELEM; i++) begin
          cmp_val_c[i] = regs[risk_reg][i][BITS-1] ? '0 : regs[risk_reg][i];
        end
      end
`endif
      default: ;
    endcase
  end

  // Register file: a retiring LOAD is overridden by a same-edge compute write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      ld_valid <= 1'b0;
      ld_reg   <= '0;
      reg_view <= '0;
    end else begin
      if (ld_valid) regs[ld_reg] <= mem_rdata;
      if (cmp_en_c) regs[risk_reg] <= cmp_val_c;
      ld_valid <= (risk_func == F_LOAD);
      ld_reg   <= risk_reg;
      reg_view <= regs[risk_reg];
    end
  end

endmodule

// File: tb/tb_risk_unit.sv
// tb_risk_unit: directed and randomized checks of risk_unit against a matrix-level model.
module tb_risk_unit;

`ifdef RISK_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   risk_func = '0;
  logic [4:0]   risk_reg = '0;
  logic [14:0]  risk_addr = '0;
  logic [13:0]  risk_stride_x = '0;
  logic [13:0]  risk_stride_y = '0;
  logic [287:0] reg_view;

  always #5 clk = ~clk;

  risk_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .risk_func     (risk_func),
    .risk_reg      (risk_reg),
    .risk_addr     (risk_addr),
    .risk_stride_x (risk_stride_x),
    .risk_stride_y (risk_stride_y),
    .reg_view      (reg_view)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: matrices as 16-element arrays, memory as a flat word array
  logic [17:0]  m_reg [32][16];
  logic [17:0]  m_mem [32768];
  bit           p_v;
  int           p_r;
  logic [17:0]  p_d [16];
  logic [287:0] exp_view;

  task automatic model_reset();
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < 16; k++) m_reg[r][k] = '0;
    p_v = 1'b0;
    p_r = 0;
    exp_view = '0;
  endtask

  task automatic poke(input int a, input logic [17:0] v);
    m_mem[a] = v;
    dut.u_mem.mem[a] = v;
  endtask

  task automatic model_edge(input int f, input int r, input int a, input int sx, input int sy);
    logic [17:0] res [16];
    logic [17:0] ld  [16];
    int          eas [16];
    longint      acc;
    int          b1;
    int          b2;
    b1 = (r + 1) % 32;
    b2 = (r + 2) % 32;
    for (int k = 0; k < 16; k++) exp_view[18*k +: 18] = m_reg[r][k];
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        eas[4*y+x] = (a + x*sx + y*sy) % 32768;
        ld[4*y+x]  = m_mem[eas[4*y+x]];
        res[4*y+x] = m_reg[r][4*y+x];
        if (f == 4) res[4*y+x] = '0;
        if (f == 5 && RELU && m_reg[r][4*y+x][17]) res[4*y+x] = '0;
        if (f == 3) begin
          acc = longint'(m_reg[r][4*y+x]);
          for (int j = 0; j < 4; j++)
            acc += longint'(m_reg[b1][4*y+j]) * longint'(m_reg[b2][4*j+x]);
          res[4*y+x] = 18'(acc & 64'h3FFFF);
        end
      end
    end
    if (f == 2)
      for (int k = 0; k < 16; k++) m_mem[eas[k]] = m_reg[r][k];
    if (p_v) m_reg[p_r] = p_d;
    if (f == 3 || f == 4 || (f == 5 && RELU)) m_reg[r] = res;
    p_v = (f == 1);
    p_r = r;
    p_d = ld;
  endtask

  task automatic drive(input int f, input int r, input int a, input int sx, input int sy);
    risk_func     = 3'(f);
    risk_reg      = 5'(r);
    risk_addr     = 15'(a);
    risk_stride_x = 14'(sx);
    risk_stride_y = 14'(sy);
  endtask

  task automatic step(input int f, input int r, input int a, input int sx, input int sy);
    drive(f, r, a, sx, sy);
    @(posedge clk);
    model_edge(f, r, a, sx, sy);
    #1;
  endtask

  task automatic test_reset();
    drive(2, 0, 0, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (reg_view !== '0) begin
      errors++; $display("FAIL reset_view got %h exp 0", reg_view);
    end
    #2 rst_n = 1'b1;
    model_reset();
    step(2, 0, 0, 1, 1);
    step(2, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    checks++;
    if (reg_view !== '0) begin
      errors++; $display("FAIL post_reset_r0 got %h exp 0", reg_view);
    end
    step(1, 1, 0, 1, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    checks++;
    if (reg_view !== '0) begin
      errors++; $display("FAIL mem0_6_zero got %h exp 0", reg_view);
    end
  endtask

  task automatic test_load();
    logic [287:0] want;
    for (int i = 0; i < 16; i++) begin
      poke(100 + i, 18'(i));
      want[18*i +: 18] = 18'(i);
    end
    step(1, 3, 100, 1, 4);
    step(0, 3, 0, 0, 0);
    checks++;
    if (reg_view !== '0) begin
      errors++; $display("FAIL load_no_forward got %h exp 0", reg_view);
    end
    step(0, 3, 0, 0, 0);
    checks++;
    if (reg_view !== want) begin
      errors++; $display("FAIL load_tile got %h exp %h", reg_view, want);
    end
  endtask

  task automatic test_store_wrap();
    logic [287:0] want;
    for (int i = 0; i < 16; i++) want[18*i +: 18] = 18'(i);
    step(2, 3, 15'h7FFE, 1, 4);
    step(1, 6, 15'h7FFE, 1, 4);
    step(0, 6, 0, 0, 0);
    step(0, 6, 0, 0, 0);
    checks++;
    if (reg_view !== want) begin
      errors++; $display("FAIL store_wrap_tile got %h exp %h", reg_view, want);
    end
    step(1, 9, 15'h000D, 0, 0);
    step(0, 9, 0, 0, 0);
    step(0, 9, 0, 0, 0);
    for (int i = 0; i < 16; i++) want[18*i +: 18] = 18'd15;
    checks++;
    if (reg_view !== want) begin
      errors++; $display("FAIL store_wrap_0x000d got %h exp %h", reg_view, want);
    end
    step(1, 9, 15'h0001, 0, 0);
    step(0, 9, 0, 0, 0);
    step(0, 9, 0, 0, 0);
    for (int i = 0; i < 16; i++) want[18*i +: 18] = 18'd3;
    checks++;
    if (reg_view !== want) begin
      errors++; $display("FAIL store_wrap_0x0001 got %h exp %h", reg_view, want);
    end
  endtask

  task automatic test_mulacc();
    logic [287:0] want;
    for (int i = 0; i < 16; i++) poke(200 + i, (i % 5 == 0) ? 18'd1 : 18'd0);
    step(1, 4, 200, 1, 4);
    step(1, 5, 100, 1, 4);
    step(4, 3, 0, 0, 0);
    step(3, 3, 0, 0, 0);
    step(0, 3, 0, 0, 0);
    for (int i = 0; i < 16; i++) want[18*i +: 18] = 18'(i);
    checks++;
    if (reg_view !== want) begin
      errors++; $display("FAIL mulacc_identity got %h exp %h", reg_view, want);
    end
    step(3, 3, 0, 0, 0);
    step(0, 3, 0, 0, 0);
    for (int i = 0; i < 16; i++) want[18*i +: 18] = 18'(2 * i);
    checks++;
    if (reg_view !== want) begin
      errors++; $display("FAIL mulacc_double got %h exp %h", reg_view, want);
    end
    // Doubling of values with bit 17 set wraps to 2*i
    for (int i = 0; i < 16; i++) poke(240 + i, 18'h20000 + 18'(i));
    step(1, 5, 240, 1, 4);
    step(4, 3, 0, 0, 0);
    step(3, 3, 0, 0, 0);
    step(3, 3, 0, 0, 0);
    step(0, 3, 0, 0, 0);
    checks++;
    if (reg_view !== want) begin
      errors++; $display("FAIL mulacc_wrap got %h exp %h", reg_view, want);
    end
  endtask

  task automatic test_relu();
    logic [287:0] want;
    poke(300, 18'h3FFFF);
    poke(301, 18'h20000);
    poke(302, 18'h1FFFF);
    for (int i = 3; i < 16; i++) poke(300 + i, 18'(i));
    step(1, 1, 300, 1, 4);
    step(0, 1, 0, 0, 0);
    step(5, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    want[0 +: 18]  = RELU ? 18'h0 : 18'h3FFFF;
    want[18 +: 18] = RELU ? 18'h0 : 18'h20000;
    want[36 +: 18] = 18'h1FFFF;
    for (int i = 3; i < 16; i++) want[18*i +: 18] = 18'(i);
    checks++;
    if (reg_view !== want) begin
      errors++; $display("FAIL relu got %h exp %h", reg_view, want);
    end
  endtask

  task automatic test_random();
    int f;
    int r;
    int sel;
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       f = 0;
        1, 2:    f = 1;
        3, 4:    f = 2;
        5, 6:    f = 3;
        7:       f = 4;
        8:       f = 5;
        default: f = int'($urandom_range(6, 7));
      endcase
      r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
      step(f, r, int'($urandom_range(0, 32767)),
           $urandom_range(0, 1) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 16383)),
           $urandom_range(0, 1) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 16383)));
      checks++;
      if (reg_view !== exp_view) begin
        errors++;
        $display("FAIL random[%0d] func=%0d reg=%0d got %h exp %h", n, f, r, reg_view, exp_view);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    step(4, 7, 0, 0, 0);
    step(0, 7, 0, 0, 0);
    drive(1, 7, 100, 1, 4);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (reg_view !== '0) begin
      errors++; $display("FAIL midload_reset_view got %h exp 0", reg_view);
    end
    drive(0, 7, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    step(0, 7, 0, 0, 0);
    step(0, 7, 0, 0, 0);
    checks++;
    if (reg_view !== '0) begin
      errors++; $display("FAIL midload_target got %h exp 0", reg_view);
    end
    step(1, 7, 100, 1, 4);
    step(0, 7, 0, 0, 0);
    step(0, 7, 0, 0, 0);
    checks++;
    if (reg_view !== exp_view) begin
      errors++; $display("FAIL post_midload_load got %h exp %h", reg_view, exp_view);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    for (int a = 0; a < 32768; a++) poke(a, 18'($urandom));
    test_reset();
    test_load();
    test_store_wrap();
    test_mulacc();
    test_relu();
    test_random();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
